// File: rtl/vic_vect_prio_pkg.sv
// Shared constants for the vectored priority resolver.
//   VIC_INTW      number of interrupt sources
//   VIC_ADDR_BW   vector address width
//   VIC_NVECT     number of vectored slots (slot 0 = highest priority)
//   VIC_PRIO_W    width of a priority level index
//   VIC_DEF_PRIO  level used by the default (non-vectored) request
//   RST_ENABLE    active level of rst
package vic_vect_prio_pkg;
   localparam int   VIC_INTW     = 32;
   localparam int   VIC_ADDR_BW  = 32;
   localparam int   VIC_NVECT    = 16;
   localparam int   VIC_PRIO_W   = 5;
   localparam int   VIC_DEF_PRIO = 16;
   localparam int   VIC_NLEVEL   = VIC_NVECT + 1;
   localparam logic RST_ENABLE   = 1'b1;
endpackage

// File: rtl/vic_prio_enc.sv
// Combinational lowest-set-bit finder.
//   req   in  N-bit request vector, bit 0 is the highest priority
//   idx   out index of the lowest set bit (VIC_DEF_PRIO when req is empty)
//   valid out any bit of req set
module vic_prio_enc
   import vic_vect_prio_pkg::*;
#(
   parameter int N  = VIC_NLEVEL,
   parameter int IW = VIC_PRIO_W
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx   = IW'(VIC_DEF_PRIO);
      valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[k]) begin
            idx   = IW'(k);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vic_vect_prio.sv
// Vectored priority resolver: picks the highest-priority pending request that
// is not masked by the in-service nesting state, and drives the registered
// IRQ request and vector address to the CPU.
//   clk, rst        clock, synchronous active-high reset
//   irq_status      masked, level-sensitive IRQ sources
//   vect_cntl       per slot 6 bits: [5] enable, [4:0] source number
//   vect_addr       per slot ISR address
//   def_vect_addr   address for non-vectored requests
//   vectaddr_rd     CPU read of VICVectAddr (acknowledge, push)
//   vectaddr_wr     CPU write of VICVectAddr (end-of-interrupt, pop)
//   irq_req         registered request, active high
//   vect_addr_out   registered vector address of the current winner
//   in_service      registered in-service mask, top bit = default level
module vic_vect_prio
   import vic_vect_prio_pkg::*;
#(
   parameter int NUM_VECT = VIC_NVECT,
   parameter int INTW     = VIC_INTW,
   parameter int ADDR_BW  = VIC_ADDR_BW
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [INTW-1:0]             irq_status,
   input  logic [NUM_VECT*6-1:0]       vect_cntl,
   input  logic [NUM_VECT*ADDR_BW-1:0] vect_addr,
   input  logic [ADDR_BW-1:0]          def_vect_addr,
   input  logic                        vectaddr_rd,
   input  logic                        vectaddr_wr,
   output logic                        irq_req,
   output logic [ADDR_BW-1:0]          vect_addr_out,
   output logic [NUM_VECT:0]           in_service
);

   localparam int NLVL = NUM_VECT + 1;
   localparam int PW   = $clog2(NLVL);
   localparam logic [PW-1:0] DEF_LVL = PW'(NUM_VECT);

   logic [INTW-1:0]    claimed;
   logic [NLVL-1:0]    cand;
   logic [NLVL-1:0]    below_mask;
   logic [NLVL-1:0]    eligible;
   logic [NLVL-1:0]    popped;
   logic [NLVL-1:0]    in_service_nxt;
   logic [PW-1:0]      mask_idx;
   logic               mask_valid;
   logic [PW-1:0]      win_idx;
   logic               win_valid;
   logic [ADDR_BW-1:0] win_addr;
   logic [PW-1:0]      w_reg;
   logic               w_valid;

   // Slot candidates; the default level catches any pending source that no
   // enabled slot claims.
   always_comb begin
      claimed = '0;
      cand    = '0;
      for (int i = 0; i < NUM_VECT; i++) begin
         if (vect_cntl[6*i+5]) begin
            claimed[vect_cntl[6*i +: 5]] = 1'b1;
            cand[i] = irq_status[vect_cntl[6*i +: 5]];
         end
      end
      cand[NUM_VECT] = |(irq_status & ~claimed);
   end

   // CPU handshake: vectaddr_rd and vectaddr_wr are single-cycle pulses with
   // no back-pressure. rd pushes the registered winner (only if it is valid),
   // wr pops the lowest set in-service bit; when both arrive together the pop
   // is applied first. The pop clears the lowest set bit with x & (x - 1).
   always_comb begin
      popped         = vectaddr_wr ? (in_service & (in_service - NLVL'(1))) : in_service;
      in_service_nxt = popped;
      if (vectaddr_rd && w_valid) begin
         in_service_nxt[w_reg] = 1'b1;
      end
   end

   // The mask level is taken from the post-update mask so irq_req drops on
   // the same edge that records the acknowledge.
   vic_prio_enc #(.N(NLVL), .IW(PW)) u_mask_enc (
      .req   (in_service_nxt),
      .idx   (mask_idx),
      .valid (mask_valid)
   );

   always_comb begin
      below_mask = '0;
      for (int k = 0; k < NLVL; k++) begin
         below_mask[k] = !mask_valid || (PW'(k) < mask_idx);
      end
      eligible = cand & below_mask;
   end

   vic_prio_enc #(.N(NLVL), .IW(PW)) u_win_enc (
      .req   (eligible),
      .idx   (win_idx),
      .valid (win_valid)
   );

   always_comb begin
      win_addr = def_vect_addr;
      for (int i = 0; i < NUM_VECT; i++) begin
         if (win_valid && (win_idx == PW'(i))) begin
            win_addr = vect_addr[ADDR_BW*i +: ADDR_BW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         in_service    <= '0;
         w_reg         <= DEF_LVL;
         w_valid       <= 1'b0;
         vect_addr_out <= '0;
      end else begin
         in_service    <= in_service_nxt;
         w_reg         <= win_idx;
         w_valid       <= win_valid;
         vect_addr_out <= win_addr;
      end
   end

   assign irq_req = w_valid;

endmodule

// File: tb/tb_vic_vect_prio.sv
module tb_vic_vect_prio;
   import vic_vect_prio_pkg::*;

   localparam int NV = 16;
   localparam int IW = 32;
   localparam int AW = 32;

   logic              clk;
   logic              rst;
   logic [IW-1:0]     irq_status;
   logic [NV*6-1:0]   vect_cntl;
   logic [NV*AW-1:0]  vect_addr;
   logic [AW-1:0]     def_vect_addr;
   logic              vectaddr_rd;
   logic              vectaddr_wr;
   logic              irq_req;
   logic [AW-1:0]     vect_addr_out;
   logic [NV:0]       in_service;

   vic_vect_prio dut (
      .clk           (clk),
      .rst           (rst),
      .irq_status    (irq_status),
      .vect_cntl     (vect_cntl),
      .vect_addr     (vect_addr),
      .def_vect_addr (def_vect_addr),
      .vectaddr_rd   (vectaddr_rd),
      .vectaddr_wr   (vectaddr_wr),
      .irq_req       (irq_req),
      .vect_addr_out (vect_addr_out),
      .in_service    (in_service)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- slot configuration seen by the model ----------------
   bit            s_en   [NV];
   int            s_src  [NV];
   logic [AW-1:0] s_addr [NV];

   // ---------------- behavioural model ----------------
   // Nesting kept as a stack of levels; the most recent push is always the
   // numerically lowest level, so it is also the masking level.
   int            m_stack[$];
   bit            m_valid;
   int            m_w;
   logic [AW-1:0] m_addr;

   function automatic logic [NV:0] model_mask();
      logic [NV:0] m;
      m = '0;
      foreach (m_stack[k]) m[m_stack[k]] = 1'b1;
      return m;
   endfunction

   initial begin
      m_valid = 1'b0;
      m_w     = 16;
      m_addr  = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_stack.delete();
            m_valid = 1'b0;
            m_w     = 16;
            m_addr  = '0;
         end else begin
            int  lim;
            bit  any_unclaimed;
            if (vectaddr_wr && m_stack.size() > 0) void'(m_stack.pop_back());
            if (vectaddr_rd && m_valid) m_stack.push_back(m_w);
            lim     = (m_stack.size() == 0) ? 17 : m_stack[$];
            m_valid = 1'b0;
            m_w     = 16;
            m_addr  = def_vect_addr;
            for (int lv = 0; lv < NV; lv++) begin
               if (!m_valid && lv < lim && s_en[lv] && irq_status[s_src[lv]]) begin
                  m_valid = 1'b1;
                  m_w     = lv;
                  m_addr  = s_addr[lv];
               end
            end
            any_unclaimed = 1'b0;
            for (int s = 0; s < IW; s++) begin
               if (irq_status[s]) begin
                  bit cl;
                  cl = 1'b0;
                  for (int lv = 0; lv < NV; lv++)
                     if (s_en[lv] && s_src[lv] == s) cl = 1'b1;
                  if (!cl) any_unclaimed = 1'b1;
               end
            end
            if (!m_valid && lim > 16 && any_unclaimed) begin
               m_valid = 1'b1;
               m_w     = 16;
               m_addr  = def_vect_addr;
            end
         end
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("irq_req_vs_model",    AW'(irq_req),    AW'(m_valid));
         check("vect_addr_vs_model",  vect_addr_out,   m_addr);
         check("in_service_vs_model", AW'(in_service), AW'(model_mask()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_slot(input int i, input bit en, input int src, input logic [AW-1:0] a);
      s_en[i]   = en;
      s_src[i]  = src;
      s_addr[i] = a;
      vect_cntl[6*i +: 6]  = {en, 5'(src)};
      vect_addr[AW*i +: AW] = a;
   endtask

   task automatic pulse(input bit rd, input bit wr);
      vectaddr_rd = rd;
      vectaddr_wr = wr;
      step(1);
      vectaddr_rd = 1'b0;
      vectaddr_wr = 1'b0;
   endtask

   // ---------------- directed stimulus with literal expectations ----------------
   initial begin
      rst           = 1'b1;
      irq_status    = '0;
      vect_cntl     = '0;
      vect_addr     = '0;
      def_vect_addr = 32'hDEF0;
      vectaddr_rd   = 1'b0;
      vectaddr_wr   = 1'b0;
      for (int i = 0; i < NV; i++) set_slot(i, 1'b0, 0, '0);
      step(3);
      rst = 1'b0;
      step(2);
      check("reset_irq_req",   AW'(irq_req),    0);
      check("reset_vect_addr", vect_addr_out,   32'hDEF0);
      check("reset_in_service", AW'(in_service), 0);

      // single vectored request on slot 3
      set_slot(3, 1'b1, 7, 32'h1000);
      irq_status = 32'h80;
      step(1);
      check("slot3_irq_req",   AW'(irq_req),  1);
      check("slot3_vect_addr", vect_addr_out, 32'h1000);
      vectaddr_rd = 1'b1;
      check("slot3_cpu_read",  vect_addr_out, 32'h1000);
      step(1);
      vectaddr_rd = 1'b0;
      check("ack3_in_service", AW'(in_service), 32'h8);
      check("ack3_irq_req",    AW'(irq_req),     0);

      // nesting: slot 1 preempts level 3
      set_slot(1, 1'b1, 2, 32'h2000);
      irq_status = 32'h84;
      step(1);
      check("nest_irq_req",   AW'(irq_req),  1);
      check("nest_vect_addr", vect_addr_out, 32'h2000);
      pulse(1'b1, 1'b0);
      check("nest_in_service", AW'(in_service), 32'hA);
      check("nest_irq_drop",   AW'(irq_req),     0);
      pulse(1'b0, 1'b1);
      check("eoi1_in_service", AW'(in_service), 32'h8);
      check("eoi1_irq_req",    AW'(irq_req),     1);
      pulse(1'b0, 1'b1);
      check("eoi2_in_service", AW'(in_service), 0);
      check("eoi2_vect_addr",  vect_addr_out,    32'h2000);

      // lower-priority slot 5 masked by level 1
      pulse(1'b1, 1'b0);
      check("mask_in_service", AW'(in_service), 32'h2);
      set_slot(5, 1'b1, 9, 32'h5000);
      irq_status = 32'h200;
      step(3);
      check("masked_irq_req",   AW'(irq_req),    0);
      check("masked_in_service", AW'(in_service), 32'h2);
      pulse(1'b0, 1'b1);
      check("unmask_irq_req",   AW'(irq_req),  1);
      check("unmask_vect_addr", vect_addr_out, 32'h5000);

      // acknowledge with nothing pending
      irq_status = '0;
      step(1);
      check("idle_irq_req", AW'(irq_req), 0);
      vectaddr_rd = 1'b1;
      check("idle_cpu_read", vect_addr_out, 32'hDEF0);
      step(1);
      vectaddr_rd = 1'b0;
      check("idle_ack_in_service", AW'(in_service), 0);

      // EOI with empty mask
      pulse(1'b0, 1'b1);
      check("empty_eoi_in_service", AW'(in_service), 0);

      // non-vectored request, then a vectored preemption
      irq_status = 32'h1;
      step(1);
      check("defv_irq_req",   AW'(irq_req),  1);
      check("defv_vect_addr", vect_addr_out, 32'hDEF0);
      pulse(1'b1, 1'b0);
      check("defv_in_service", AW'(in_service), 32'h10000);
      check("defv_irq_drop",   AW'(irq_req),     0);
      set_slot(9, 1'b1, 12, 32'h9000);
      irq_status = 32'h1001;
      step(1);
      check("preempt_irq_req",   AW'(irq_req),  1);
      check("preempt_vect_addr", vect_addr_out, 32'h9000);
      pulse(1'b1, 1'b0);
      check("preempt_in_service", AW'(in_service), 32'h10200);
      pulse(1'b0, 1'b1);
      check("preempt_eoi1", AW'(in_service), 32'h10000);
      pulse(1'b0, 1'b1);
      check("preempt_eoi2", AW'(in_service), 0);

      // duplicate source: slot 1 and slot 6 both on src 2
      set_slot(6, 1'b1, 2, 32'h6000);
      irq_status = 32'h4;
      step(1);
      check("dup_vect_addr", vect_addr_out, 32'h2000);

      // simultaneous EOI and acknowledge
      irq_status = 32'h80;
      step(1);
      pulse(1'b1, 1'b0);
      check("rw_setup_in_service", AW'(in_service), 32'h8);
      irq_status = 32'h84;
      step(1);
      check("rw_winner_addr", vect_addr_out, 32'h2000);
      pulse(1'b1, 1'b1);
      check("rw_in_service", AW'(in_service), 32'h2);

      // config change does not disturb in_service
      set_slot(1, 1'b0, 0, '0);
      step(1);
      check("cfg_change_in_service", AW'(in_service), 32'h2);

      // reset wins over acknowledge
      vectaddr_rd = 1'b1;
      rst         = 1'b1;
      step(1);
      rst         = 1'b0;
      vectaddr_rd = 1'b0;
      check("rst_rd_in_service", AW'(in_service), 0);
      check("rst_rd_irq_req",    AW'(irq_req),    0);
      check("rst_rd_vect_addr",  vect_addr_out,   0);

      step(3);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/vic_vect_prio.md
Name: vic_vect_prio

Overview:
- Vectored priority resolver sitting directly downstream of the VIC register/status block.
- Consumes the masked IRQ status and the 16 vector-control/vector-address slots; picks the highest-priority pending request and drives the IRQ request and vector address to the CPU.
- Tracks nested in-service priority levels. A CPU read of VICVectAddr acknowledges the current request (push); a CPU write to VICVectAddr signals end-of-interrupt (pop).

Parameters:
- NUM_VECT, 16, number of vectored slots; slot 0 is the highest priority.
- INTW, 32, number of interrupt sources (matches `VIC_INTW`).
- ADDR_BW, 32, vector address width (matches `ADDR_BW`).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- irq_status  in  INTW  IRQ sources after enable/select masking, level-sensitive.
- vect_cntl  in  NUM_VECT*6  per slot i, bits [6i+5:6i]: bit 5 is the enable, bits 4:0 are the source number.
- vect_addr  in  NUM_VECT*ADDR_BW  per slot i, bits [ADDR_BW*(i+1)-1:ADDR_BW*i] hold the ISR address.
- def_vect_addr  in  ADDR_BW  address for non-vectored IRQs.
- vectaddr_rd  in  1  one-cycle pulse: CPU read of VICVectAddr (acknowledge).
- vectaddr_wr  in  1  one-cycle pulse: CPU write to VICVectAddr (end-of-interrupt).
- irq_req  out  1  registered, active-high IRQ request; the top level inverts it to drive nVICIRQ.
- vect_addr_out  out  ADDR_BW  registered vector address of the current winner.
- in_service  out  NUM_VECT+1  registered in-service mask; bit 16 is the default (non-vectored) level.

Behaviour:
- Priority levels 0..15 map to vectored slots. Level 16 is the default level.
- Slot i is a candidate when vect_cntl enable=1 and irq_status[src_i]=1.
- The default level is a candidate when any irq_status bit is set that no enabled slot claims.
- Masking level L is the lowest set bit of in_service, or 17 if in_service is empty. Only candidates with level < L are eligible.
- Winner W is the lowest eligible level. Duplicate source numbers across slots resolve to the lowest slot.
- Latency: registered every cycle, so irq_req and vect_addr_out reflect irq_status/config from the previous cycle.
  - No eligible candidate: irq_req=0 and vect_addr_out=def_vect_addr.
  - Winner W<16: vect_addr_out = vect_addr[W].
  - Winner W=16: vect_addr_out = def_vect_addr.
- The CPU reads vect_addr_out in the same cycle that vectaddr_rd is asserted.
- Acknowledge (vectaddr_rd=1 with the registered winner valid): set in_service[W_reg] on the next edge. irq_req then drops unless a strictly higher level is pending.
- Acknowledge with no valid winner: in_service unchanged. The CPU still sees def_vect_addr.
- EOI (vectaddr_wr=1): clear the lowest set bit of in_service. With in_service empty, ignore (no error).
- vectaddr_rd and vectaddr_wr in the same cycle: pop first, then push W_reg. W_reg was computed against the pre-pop mask, so it is always at a level above the popped one.
- Nesting depth is bounded at 17 by construction. Re-acknowledging a level that is already set is a no-op.
- irq_status deasserting after acknowledge does not clear in_service; only EOI clears it.
- Config changes while a level is in service do not alter in_service.
- Reset: in_service=0, irq_req=0, vect_addr_out=0, W_reg=16 with valid=0. Reset takes precedence over rd/wr in the same cycle.
- Internal state: in_service register, W_reg (5 bits) with valid flag, vect_addr_out register. There is no other FSM; the in_service mask is the nesting state.

Decomposition:
- Shared defs.v constants: `VIC_INTW`, `ADDR_BW`, `VIC_NVECT`=16, `VIC_PRIO_W`=5, `VIC_DEF_PRIO`=16, `RstEnable`=1'b1.
- One sub-module, vic_prio_enc: a combinational 17-bit lowest-set-bit finder with index and valid outputs. It is instantiated twice: once for the winner among eligible candidates, once for the mask level L / EOI target.

Test Plan:
- Reset, then irq_status=0x0 -> irq_req=0, vect_addr_out=def_vect_addr, in_service=0.
- Slot 3 = {en=1, src=7}, vect_addr[3]=0x1000, irq_status=0x80 -> one cycle later irq_req=1, vect_addr_out=0x1000. Pulse vectaddr_rd -> in_service=0x00008, irq_req=0.
- Nesting:
  - With level 3 in service, set slot 1 {src=2}=0x2000 and irq_status=0x84 -> irq_req=1, vect_addr_out=0x2000. Acknowledge -> in_service=0x0000A.
  - EOI -> in_service=0x00008.
  - EOI -> 0x0; irq_req reasserts for any source still pending.
- Lower-priority masking: level 1 in service, slot 5 pending -> irq_req stays 0 until EOI.
- Non-vectored: irq_status=0x1 with no slot claiming src 0 -> vect_addr_out=def_vect_addr=0xDEF0. Acknowledge -> in_service=0x10000. A vectored slot 9 request then preempts -> irq_req=1.
- Edge cases:
  - vectaddr_rd and vectaddr_wr together with in_service=0x00008 and winner 1 -> in_service=0x00002.
  - vectaddr_wr with in_service=0 -> unchanged.
  - rst asserted together with vectaddr_rd -> all cleared.
